register_file_dp: RTL and testbench

REGISTER_FILE_DP -- requirements
Module: register_file_dp

---
 rtl/register_file_dp.sv | 110 +++++++++++
 tb/tb_register_file_dp.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_dp.sv
// register_file_dp: dual-read, dual-write register file with entry 0 hardwired
// to zero. After reset or a soft clear, the array is swept one entry per clock
// edge (entries 1..NREG-1) and is only usable once ready rises.
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data to
// the read ports (port B data preferred over port A).
module register_file_dp #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] wd3,
  input  logic            we3,
  input  logic [AW-1:0]   a4,
  input  logic [XLEN-1:0] wd4,
  input  logic            we4,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            ready
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] mem [NREG];

  // Control machine: sweep the array in CLEAR, accept writes in READY.
  // The counter stops at its terminal value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= AW'(1);
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (cnt == LAST) begin
            state <= READY;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        READY: begin
          if (clr) begin
            state <= CLEAR;
            cnt   <= AW'(1);
            ready <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= AW'(1);
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Array update: zero one entry per edge while clearing, otherwise apply the
  // two write ports; port B is written last so it wins on an address clash.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (!clr) begin
        if (we3 && (a3 != '0)) begin
          mem[a3] <= wd3;
        end
        if (we4 && (a4 != '0)) begin
          mem[a4] <= wd4;
        end
      end
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = '0;
    if (ready && (addr != '0)) begin
      val = mem[addr];
`ifdef RF_BYPASS_EN
      if (we4 && (a4 == addr)) begin
        val = wd4;
      end else if (we3 && (a3 == addr)) begin
        val = wd3;
      end
`endif
    end
    return val;
  endfunction

  // Combinational read ports; both read zero while the array is not ready.
  always_comb begin
    rd1 = read_port(a1);
    rd2 = read_port(a2);
  end

endmodule

// File: tb/tb_register_file_dp.sv
// tb_register_file_dp: directed self-checking bench for register_file_dp with
// default parameters (XLEN=32, NREG=32). Honours RF_BYPASS_EN when defined.
module tb_register_file_dp;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        clr;
  logic [4:0]  a1, a2, a3, a4;
  logic [31:0] wd3, wd4;
  logic        we3, we4;
  logic [31:0] rd1, rd2;
  logic        ready;

  int total;
  int bad;

  typedef struct {
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we4;
    logic [4:0]  a4;
    logic [31:0] wd4;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [10];

  register_file_dp #(.XLEN(32), .NREG(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .wd3   (wd3),
    .we3   (we3),
    .a4    (a4),
    .wd4   (wd4),
    .we4   (we4),
    .rd1   (rd1),
    .rd2   (rd2),
    .ready (ready)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    we3 = v.we3; a3 = v.a3; wd3 = v.wd3;
    we4 = v.we4; a4 = v.a4; wd4 = v.wd4;
    a1  = v.a1;  a2 = v.a2;
  endtask

  task automatic idleWrites();
    we3 = 1'b0; a3 = '0; wd3 = '0;
    we4 = 1'b0; a4 = '0; wd4 = '0;
  endtask

  // Count edges until ready is seen high, bounded to avoid hanging.
  task automatic countToReady(output int n);
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk);
      n++;
      #1;
    end
  endtask

  task automatic readAt(input logic [4:0] x1, input logic [4:0] x2,
                        output logic [31:0] r1, output logic [31:0] r2);
    @(negedge clk);
    a1 = x1;
    a2 = x2;
    #1;
    r1 = rd1;
    r2 = rd2;
  endtask

  initial begin
    int n;
    logic [31:0] r1, r2;
    logic all_zero;

    total = 0;
    bad   = 0;

    vecs[0] = '{1'b1, 5'd5,  32'h11111111, 1'b1, 5'd6,  32'h22222222, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'h11111111, 32'h22222222};
    vecs[2] = '{1'b1, 5'd7,  32'hAAAA0000, 1'b1, 5'd7,  32'h0000BBBB, 5'd5,  5'd6,  32'h11111111, 32'h22222222};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  32'h0000BBBB, 32'h0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h0000BBBB};
    vecs[5] = '{1'b1, 5'd1,  32'h00000001, 1'b1, 5'd31, 32'hCAFEF00D, 5'd5,  5'd7,  32'h11111111, 32'h0000BBBB};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h0000FFFF, 5'd31, 5'd1,  32'hCAFEF00D, 32'h00000001};
    vecs[7] = '{1'b1, 5'd9,  32'h00000001, 1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 32'h0,        32'hCAFEF00D};
    vecs[8] = '{1'b1, 5'd3,  32'h0000DEAD, 1'b0, 5'd0,  32'h0,        5'd9,  5'd1,  32'h00000001, 32'h00000001};
    vecs[9] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,  5'd9,  32'h0000DEAD, 32'h00000001};

    // Reset for two edges, then the initial clear sweep.
    rst = 1'b1; clr = 1'b0; a1 = 5'd5; a2 = 5'd31;
    idleWrites();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", {31'b0, ready}, 32'h0);
    checkOutput("reset_rd1", rd1, 32'h0);
    checkOutput("reset_rd2", rd2, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    // A write late in the sweep, after entry 2 was already zeroed, must be ignored.
    n = 0;
    while (!ready && n < 100) begin
      we3 = (n >= 20); a3 = 5'd2; wd3 = 32'h0BADF00D;
      @(posedge clk);
      n++;
      #1;
    end
    idleWrites();
    checkOutput("init_clear_edges", n, 31);

    all_zero = 1'b1;
    for (int i = 0; i < 32; i++) begin
      readAt(5'(i), 5'(31 - i), r1, r2);
      if (r1 !== 32'h0 || r2 !== 32'h0) all_zero = 1'b0;
    end
    checkOutput("init_all_zero", {31'b0, all_zero}, 32'h1);

    // Table-driven writes and reads in READY.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
      checkOutput($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
    end
    @(negedge clk);
    idleWrites();

    // Same-cycle read of an address being written (entry 9 holds 1).
    @(negedge clk);
    a1 = 5'd9; a2 = 5'd3;
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'h12345678;
    #1;
    checkOutput("bypass_rd1", rd1, BYP ? 32'h12345678 : 32'h00000001);
    checkOutput("bypass_rd2", rd2, 32'h0000DEAD);
    @(negedge clk);
    idleWrites();
    #1;
    checkOutput("after_write_9", rd1, 32'h12345678);

    // Both ports target entry 10 (previously 0): port B preferred.
    @(negedge clk);
    a1 = 5'd10;
    we3 = 1'b1; a3 = 5'd10; wd3 = 32'h0000AAAA;
    we4 = 1'b1; a4 = 5'd10; wd4 = 32'h0000BBBB;
    #1;
    checkOutput("bypass_prio", rd1, BYP ? 32'h0000BBBB : 32'h0);
    @(negedge clk);
    idleWrites();
    #1;
    checkOutput("after_write_10", rd1, 32'h0000BBBB);

    // Soft clear with a simultaneous write; a second clr mid-sweep is ignored.
    @(negedge clk);
    clr = 1'b1; we3 = 1'b1; a3 = 5'd4; wd3 = 32'h00004444;
    a1 = 5'd7;
    @(posedge clk);
    #1;
    clr = 1'b0;
    idleWrites();
    checkOutput("clr_ready_low", {31'b0, ready}, 32'h0);
    n = 0;
    while (!ready && n < 100) begin
      clr = (n == 19);
      if (n == 2) checkOutput("clear_rd1_zero", rd1, 32'h0);
      @(posedge clk);
      n++;
      #1;
    end
    clr = 1'b0;
    checkOutput("soft_clear_edges", n, 31);
    readAt(5'd3, 5'd4, r1, r2);
    checkOutput("soft_clear_e3", r1, 32'h0);
    checkOutput("soft_clear_e4", r2, 32'h0);

    // Reset at the tenth edge of a clear sweep, with writes held active.
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'h55555555;
    we4 = 1'b1; a4 = 5'd6; wd4 = 32'h66666666;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_ready_low", {31'b0, ready}, 32'h0);
    countToReady(n);
    checkOutput("midrst_edges", n, 31);
    @(negedge clk);
    idleWrites();
    readAt(5'd5, 5'd6, r1, r2);
    checkOutput("midrst_e5", r1, 32'h0);
    checkOutput("midrst_e6", r2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
